alu16_stage: RTL and testbench
==============================

// Module: alu16_stage
// PURPOSE
//  Registered Hack-style 16-bit ALU stage. Consumes operand pairs, computes x&y or x+y
//  with zx/nx/zy/ny/no pre/post conditioning, and produces out/zr/ng to the
//  downstream register stage.
//  The bitwise-AND path is the 16-bit per-bit AND gate bank; the add path is a
//  16-bit ripple adder.
//  Valid/ready handshakes on both sides. A 2-entry skid buffer gives full throughput.
// PARAMETERS
//  WIDTH     16  datapath width; bit index 0 = MSB (vectors are [0:WIDTH-1])
//  USE_SKID  1   1: registered in_ready with 2-entry skid; 0: 1-entry, in_ready combinational
// PORTS
//  clk        in   1      single clock; all state updates on rising edge
//  reset      in   1      synchronous, active-high reset
//  in_valid   in   1      x/y/ctrl valid this cycle
//  in_ready   out  1      stage accepts input this cycle
//  x          in   WIDTH  operand x
//  y          in   WIDTH  operand y
//  ctrl       in   6      [0]=zx [1]=nx [2]=zy [3]=ny [4]=f [5]=no
//  out_valid  out  1      out/zr/ng valid
//  out_ready  in   1      downstream accepts this cycle
//  out        out  WIDTH  ALU result
//  zr         out  1      1 when out == 0
//  ng         out  1      out[0] (sign bit, MSB)
// BEHAVIOUR
//  - Function: x1=zx?0:x; x2=nx?~x1:x1; same for y (zy/ny). f=0: r=x2&y2; f=1: r=x2+y2
//    mod 2^WIDTH, carry out discarded. out = no?~r:r.
//  - zr and ng are computed from the final out. They are registered with out.
//  - Transfers: input on in_valid&in_ready; output on out_valid&out_ready.
//  - Latency 1: data accepted at edge N is on out from edge N+1 onward.
//  - State (USE_SKID=1):
//    EMPTY: main and skid both invalid.
//    ONE:   main valid.
//    FULL:  main and skid both valid.
//  - Transitions:
//    EMPTY --in xfer--> ONE.
//    ONE   --in xfer & no out xfer--> FULL (new result goes to skid).
//    ONE   --out xfer & no in xfer--> EMPTY.
//    ONE   --both xfers--> ONE (main gets the new result).
//    FULL  --out xfer--> ONE (skid moves to main); no input is accepted in FULL.
//  - in_ready = (state != FULL). It is a registered flop and has no combinational path
//    from out_ready.
//  - USE_SKID=0: single main entry. in_ready = !out_valid | out_ready (combinational).
//  - Ordering: results leave in strict acceptance order. Nothing is dropped or duplicated.
//  - Outputs are stable while out_valid=1 and out_ready=0.
//  - in_valid while in_ready=0 is ignored; the source holds its data.
//  - x/y/ctrl are don't-care when in_valid=0; no state change.
//  - Reset (any cycle, including mid-transfer or while FULL):
//    state=EMPTY; out_valid=0; in_ready=1 (released in the cycle after reset);
//    out=0; zr=0; ng=0; skid contents discarded.
//    reset dominates any simultaneous transfer.
// TESTING
//  1. ctrl=000010, x=0x0005, y=0x0003, out_ready=1 -> next cycle: out=0x0008, zr=0, ng=0.
//  2. ctrl=000000, x=0x00FF, y=0x0F0F -> out=0x000F.
//     Then ctrl=101010 (constant 0) -> out=0x0000, zr=1, ng=0.
//  3. ctrl=010011 (x-y), x=0x0003, y=0x0005 -> out=0xFFFE, ng=1, zr=0.
//     Then x=0x8000, y=0x8000, ctrl=000010 -> out=0x0000, zr=1 (overflow wraps).
//  4. Backpressure: out_ready=0, offer 3 back-to-back inputs A,B,C.
//     -> A, B accepted; in_ready=0 from the cycle after B; C held.
//     Release out_ready -> A, B, C delivered in order, no gaps after the first.
//  5. Throughput: in_valid=1 and out_ready=1 for 100 cycles with random x/y/ctrl
//     -> one result per cycle, matching the reference model, state never FULL.
//  6. Reset asserted for 1 cycle while FULL -> next cycle out_valid=0, out=0, in_ready=1;
//     the first input after reset appears alone, 1 cycle later.

Source files
------------

// File: rtl/alu16_stage.sv
// Registered Hack-style ALU stage with valid/ready handshakes on both sides.
// Bit 0 is the MSB of every vector; USE_SKID selects a 2-entry skid or a 1-entry stage.
module alu16_stage #(
  parameter int WIDTH    = 16,
  parameter bit USE_SKID = 1'b1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [0:WIDTH-1] x_i,
  input  logic [0:WIDTH-1] y_i,
  input  logic [0:5]       ctrl_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [0:WIDTH-1] out_o,
  output logic             zr_o,
  output logic             ng_o
);

  typedef struct packed {
    logic [0:WIDTH-1] data;
    logic             zr;
    logic             ng;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  logic [0:WIDTH-1] x1, x2, y1, y2, andRes, sumRes, preNeg, result;
  logic             carry;
  entry_t           entryNew;

  // Carry ripples from the LSB (index WIDTH-1) toward the MSB (index 0).
  always_comb begin
    x1     = ctrl_i[0] ? '0 : x_i;
    x2     = ctrl_i[1] ? ~x1 : x1;
    y1     = ctrl_i[2] ? '0 : y_i;
    y2     = ctrl_i[3] ? ~y1 : y1;
    andRes = x2 & y2;
    sumRes = '0;
    carry  = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      sumRes[i] = x2[i] ^ y2[i] ^ carry;
      carry     = (x2[i] & y2[i]) | (carry & (x2[i] ^ y2[i]));
    end
    preNeg        = ctrl_i[4] ? sumRes : andRes;
    result        = ctrl_i[5] ? ~preNeg : preNeg;
    entryNew.data = result;
    entryNew.zr   = (result == '0);
    entryNew.ng   = result[0];
  end

  generate
    if (USE_SKID) begin : gSkid
      state_t state_q, state_d;
      entry_t main_q, main_d, skid_q, skid_d;
      logic   inReady_q;
      logic   inXfer, outXfer;

      assign inXfer  = in_valid_i & inReady_q;
      assign outXfer = (state_q != EMPTY) & out_ready_i;

      // in_ready is a flop mirroring "next state is not FULL", so it never sees out_ready combinationally.
      always_ff @(posedge clk_i) begin
        if (reset_i) begin
          state_q   <= EMPTY;
          main_q    <= '0;
          skid_q    <= '0;
          inReady_q <= 1'b1;
        end else begin
          state_q   <= state_d;
          main_q    <= main_d;
          skid_q    <= skid_d;
          inReady_q <= (state_d != FULL);
        end
      end

      always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
          EMPTY: begin
            if (inXfer) begin
              main_d  = entryNew;
              state_d = ONE;
            end
          end
          ONE: begin
            if (inXfer && outXfer) begin
              main_d = entryNew;
            end else if (inXfer) begin
              skid_d  = entryNew;
              state_d = FULL;
            end else if (outXfer) begin
              state_d = EMPTY;
            end
          end
          FULL: begin
            if (outXfer) begin
              main_d  = skid_q;
              state_d = ONE;
            end
          end
          default: state_d = EMPTY;
        endcase
      end

      assign in_ready_o  = inReady_q;
      assign out_valid_o = (state_q != EMPTY);
      assign out_o       = main_q.data;
      assign zr_o        = main_q.zr;
      assign ng_o        = main_q.ng;
    end else begin : gSingle
      entry_t main_q;
      logic   mainValid_q;
      logic   inReady;

      assign inReady = ~mainValid_q | out_ready_i;

      always_ff @(posedge clk_i) begin
        if (reset_i) begin
          mainValid_q <= 1'b0;
          main_q      <= '0;
        end else if (in_valid_i && inReady) begin
          mainValid_q <= 1'b1;
          main_q      <= entryNew;
        end else if (out_ready_i) begin
          mainValid_q <= 1'b0;
        end
      end

      assign in_ready_o  = inReady;
      assign out_valid_o = mainValid_q;
      assign out_o       = main_q.data;
      assign zr_o        = main_q.zr;
      assign ng_o        = main_q.ng;
    end
  endgenerate

endmodule

// File: tb/tb_alu16_stage.sv
// Directed self-checking bench for alu16_stage (skid configuration).
// Inputs change 1 time unit after each rising edge; outputs are sampled at the same point.
module tb_alu16_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        inValid;
  logic        inReady;
  logic [0:15] xIn, yIn;
  logic [0:5]  ctrlIn;
  logic        outValid;
  logic        outReady;
  logic [0:15] outData;
  logic        zr, ng;

  int compared   = 0;
  int mismatched = 0;

  alu16_stage #(.WIDTH(16), .USE_SKID(1'b1)) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .in_valid_i  (inValid),
    .in_ready_o  (inReady),
    .x_i         (xIn),
    .y_i         (yIn),
    .ctrl_i      (ctrlIn),
    .out_valid_o (outValid),
    .out_ready_i (outReady),
    .out_o       (outData),
    .zr_o        (zr),
    .ng_o        (ng)
  );

  always #5 clk = ~clk;

  // Reference: result followed by zr and ng, built with plain operators.
  function automatic logic [0:17] aluModel(input logic [0:15] xa, input logic [0:15] ya,
                                           input logic [0:5] c);
    logic [0:15] a, b, r;
    a = c[0] ? 16'h0000 : xa;
    if (c[1]) a = ~a;
    b = c[2] ? 16'h0000 : ya;
    if (c[3]) b = ~b;
    r = c[4] ? (a + b) : (a & b);
    if (c[5]) r = ~r;
    return {r, (r == 16'h0000), r[0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [0:15] xa, input logic [0:15] ya,
                               input logic [0:5] c, input logic ordy);
    inValid  = v;
    xIn      = xa;
    yIn      = ya;
    ctrlIn   = c;
    outReady = ordy;
  endtask

  task automatic checkOutput(input string tag, input logic [0:17] expRes);
    logic [0:18] obs, expv;
    obs  = {outValid, outData, zr, ng};
    expv = {1'b1, expRes};
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed valid/out/zr/ng=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic checkReset(input string tag);
    logic [0:18] obs;
    obs = {outValid, outData, zr, ng};
    compared++;
    assert (obs === 19'h0) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed valid/out/zr/ng=%h expected=%h", tag, obs, 19'h0);
    end
  endtask

  task automatic checkIdle(input string tag);
    compared++;
    assert (outValid === 1'b0) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed out_valid=%b expected=0", tag, outValid);
    end
  endtask

  task automatic checkReady(input string tag, input logic expReady);
    compared++;
    assert (inReady === expReady) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed in_ready=%b expected=%b", tag, inReady, expReady);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [0:15] rx, ry;
    logic [0:5]  rc;

    reset = 1'b1;
    applyStimulus(1'b0, 16'h0000, 16'h0000, 6'b000000, 1'b1);
    tick();
    tick();
    checkReset("reset_outputs");
    checkReady("reset_ready", 1'b1);
    reset = 1'b0;

    applyStimulus(1'b1, 16'h0005, 16'h0003, 6'b000010, 1'b1);
    tick();
    checkOutput("add_5_3", {16'h0008, 1'b0, 1'b0});

    applyStimulus(1'b1, 16'h00FF, 16'h0F0F, 6'b000000, 1'b1);
    tick();
    checkOutput("and_ff_0f0f", {16'h000F, 1'b0, 1'b0});
    applyStimulus(1'b1, 16'h00FF, 16'h0F0F, 6'b101010, 1'b1);
    tick();
    checkOutput("const_zero", {16'h0000, 1'b1, 1'b0});

    applyStimulus(1'b1, 16'h0003, 16'h0005, 6'b010011, 1'b1);
    tick();
    checkOutput("x_minus_y", {16'hFFFE, 1'b0, 1'b1});
    applyStimulus(1'b1, 16'h8000, 16'h8000, 6'b000010, 1'b1);
    tick();
    checkOutput("add_overflow_wrap", {16'h0000, 1'b1, 1'b0});

    applyStimulus(1'b0, 16'h0000, 16'h0000, 6'b000000, 1'b1);
    tick();
    checkIdle("drain_empty");
    checkReady("drain_ready", 1'b1);

    // Backpressure: A=1+2, B=0x10+0x20, C=0x00F0&0x0FF0.
    applyStimulus(1'b1, 16'h0001, 16'h0002, 6'b000010, 1'b0);
    tick();
    checkOutput("bp_A_held", {16'h0003, 1'b0, 1'b0});
    checkReady("bp_ready_after_A", 1'b1);
    applyStimulus(1'b1, 16'h0010, 16'h0020, 6'b000010, 1'b0);
    tick();
    checkOutput("bp_A_still", {16'h0003, 1'b0, 1'b0});
    checkReady("bp_ready_after_B", 1'b0);
    applyStimulus(1'b1, 16'h00F0, 16'h0FF0, 6'b000000, 1'b0);
    tick();
    checkOutput("bp_A_stable", {16'h0003, 1'b0, 1'b0});
    checkReady("bp_C_blocked", 1'b0);
    tick();
    checkOutput("bp_A_stable2", {16'h0003, 1'b0, 1'b0});
    outReady = 1'b1;
    tick();
    checkOutput("bp_B_out", {16'h0030, 1'b0, 1'b0});
    checkReady("bp_ready_reopen", 1'b1);
    tick();
    checkOutput("bp_C_out", {16'h00F0, 1'b0, 1'b0});
    inValid = 1'b0;
    tick();
    checkIdle("bp_drained");

    // Full-rate stream against the reference model.
    for (int i = 0; i < 100; i++) begin
      rx = 16'($urandom);
      ry = 16'($urandom);
      rc = 6'($urandom_range(0, 63));
      applyStimulus(1'b1, rx, ry, rc, 1'b1);
      tick();
      checkOutput("stream_result", aluModel(rx, ry, rc));
      checkReady("stream_never_full", 1'b1);
    end

    // Fill both entries, then reset while FULL with transfers offered.
    applyStimulus(1'b1, 16'h1234, 16'h0001, 6'b000010, 1'b0);
    tick();
    applyStimulus(1'b1, 16'h4321, 16'h0001, 6'b000010, 1'b0);
    tick();
    checkReady("full_before_reset", 1'b0);
    reset    = 1'b1;
    outReady = 1'b1;
    tick();
    reset = 1'b0;
    checkReset("reset_while_full");
    checkReady("reset_ready_release", 1'b1);
    applyStimulus(1'b1, 16'h0007, 16'h0009, 6'b000010, 1'b1);
    tick();
    checkOutput("first_after_reset", {16'h0010, 1'b0, 1'b0});
    inValid = 1'b0;
    tick();
    checkIdle("no_stale_skid");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
